// File: rtl/cnn_result_collector_pkg.sv
// Shared CNN sizing and collector state encoding.
// Keeps the collector consistent with the fully-connected layer.
package cnn_result_collector_pkg;

   localparam int num_classes = 10;
   localparam int data_width  = 32;
   localparam int class_width = $clog2(num_classes);

   localparam logic [class_width-1:0] last_idx =
      class_width'(num_classes - 1);

   typedef enum logic {
      COLLECT,
      RESULT
   } state_e;

endpackage

// File: rtl/cnn_result_collector_argmax_tracker.sv
// Registered running max with index.
// Ties keep the earliest index.
module argmax_tracker
   import cnn_result_collector_pkg::*;
(
   input  logic                   clk,
   input  logic                   clear_i,
   input  logic                   accept_i,
   input  logic [class_width-1:0] idx_i,
   input  logic [data_width-1:0]  data_i,
   output logic [data_width-1:0]  best_o,
   output logic [class_width-1:0] best_idx_o
);

   logic [data_width-1:0]  best_q, best_d;
   logic [class_width-1:0] bidx_q, bidx_d;

   always_comb begin
      best_d = best_q;
      bidx_d = bidx_q;
      if (clear_i) begin
         best_d = '0;
         bidx_d = '0;
      end else if (accept_i &&
                   (idx_i == '0 ||
                    $signed(data_i) > $signed(best_q))) begin
         best_d = data_i;
         bidx_d = idx_i;
      end
   end

   always_ff @(posedge clk) begin
      best_q <= best_d;
      bidx_q <= bidx_d;
   end

   assign best_o     = best_q;
   assign best_idx_o = bidx_q;

endmodule

// File: rtl/cnn_result_collector.sv
// CNN output endpoint: buffers one frame of class scores,
// tracks the argmax and hands out the predicted class.
module cnn_result_collector
   import cnn_result_collector_pkg::*;
(
   input  logic                   clk,
   input  logic                   rstb,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [data_width-1:0]  in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [class_width-1:0] out_class,
   output logic [data_width-1:0]  out_score,
   output logic                   out_error,
   input  logic [class_width-1:0] rd_addr,
   output logic [data_width-1:0]  rd_data,
   output logic [15:0]            frame_count
);

   state_e                 state_q, state_d;
   logic [class_width-1:0] idx_q, idx_d;
   logic                   err_q, err_d;
   logic [15:0]            fc_q, fc_d;
   logic [data_width-1:0]  rd_q, rd_d;
   logic [data_width-1:0]  buf_q [num_classes];

   logic accept, done, frame_end;

   // Gate with reset so nothing handshakes while held in reset.
   assign in_ready  = (state_q == COLLECT) && !rstb;
   assign out_valid = (state_q == RESULT) && !rstb;
   assign accept    = in_valid && in_ready;
   assign done      = out_valid && out_ready;
   assign frame_end = accept && (in_last || idx_q == last_idx);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      err_d   = err_q;
      fc_d    = fc_q;
      unique case (state_q)
         COLLECT: begin
            if (accept) begin
               idx_d = idx_q + 1'b1;
            end
            if (frame_end) begin
               state_d = RESULT;
               err_d   = !(in_last && idx_q == last_idx);
            end
         end
         RESULT: begin
            if (done) begin
               state_d = COLLECT;
               fc_d    = fc_q + 16'd1;
               idx_d   = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_comb begin
      rd_d = '0;
      if (rd_addr <= last_idx) begin
         rd_d = buf_q[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rstb) begin
         state_q <= COLLECT;
         idx_q   <= '0;
         err_q   <= 1'b0;
         fc_q    <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         fc_q    <= fc_d;
         rd_q    <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         buf_q[idx_q] <= in_data;
      end
   end

   argmax_tracker u_argmax (
      .clk        (clk),
      .clear_i    (rstb || done),
      .accept_i   (accept),
      .idx_i      (idx_q),
      .data_i     (in_data),
      .best_o     (out_score),
      .best_idx_o (out_class)
   );

   assign out_error   = err_q;
   assign rd_data     = rd_q;
   assign frame_count = fc_q;

endmodule

// File: tb/tb_cnn_result_collector.sv
// Directed bench for cnn_result_collector.
// Each task drives one scenario and checks its own results.
module tb_cnn_result_collector;

   logic        clk;
   logic        rstb;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_class;
   logic [31:0] out_score;
   logic        out_error;
   logic [3:0]  rd_addr;
   logic [31:0] rd_data;
   logic [15:0] frame_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] vals [10];

   cnn_result_collector dut (
      .clk         (clk),
      .rstb        (rstb),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_class   (out_class),
      .out_score   (out_score),
      .out_error   (out_error),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .frame_count (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives vals[0..n-1] one per cycle; in_last on the final
   // beat only when last_end is set.
   task automatic send_frame(input int n, input bit last_end);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = vals[i];
         in_last  = last_end && (i == n - 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic test_reset();
      rstb = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      in_last = 1'b0;
      out_ready = 1'b0;
      rd_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs in_ready=%b out_valid=%b want 0 0",
                  in_ready, out_valid);
      end
      checks++;
      if (frame_count !== 16'd0 || rd_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_regs fc=%0d rd=%h want 0 0",
                  frame_count, rd_data);
      end
      rstb = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release in_ready=%b want 1", in_ready);
      end
   endtask

   task automatic test_ascending();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) vals[i] = 32'(10 * (i + 1));
      send_frame(10, 1'b1);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL asc_latency out_valid=%b want 1", out_valid);
      end
      checks++;
      if (out_class !== 4'd9 || out_score !== 32'd100 ||
          out_error !== 1'b0) begin
         errors++;
         $display("FAIL asc_result cls=%0d sc=%0d err=%b want 9 100 0",
                  out_class, out_score, out_error);
      end
      @(posedge clk);
      #1;
      checks++;
      if (frame_count !== 16'd1 || in_ready !== 1'b1 ||
          out_valid !== 1'b0) begin
         errors++;
         $display("FAIL asc_done fc=%0d rdy=%b ov=%b want 1 1 0",
                  frame_count, in_ready, out_valid);
      end
      rd_addr = 4'd5;
      @(posedge clk);
      #1;
      checks++;
      if (rd_data !== 32'd60) begin
         errors++;
         $display("FAIL asc_readback rd=%0d want 60", rd_data);
      end
      rd_addr = 4'd12;
      @(posedge clk);
      #1;
      checks++;
      if (rd_data !== 32'd0) begin
         errors++;
         $display("FAIL rd_oob rd=%h want 0", rd_data);
      end
   endtask

   task automatic test_negative();
      for (int i = 0; i < 10; i++) vals[i] = -32'sd100;
      vals[3] = -32'sd5;
      vals[7] = -32'sd5;
      send_frame(10, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_class !== 4'd3 ||
          out_score !== 32'hFFFFFFFB || out_error !== 1'b0) begin
         errors++;
         $display("FAIL neg_tie ov=%b cls=%0d sc=%h err=%b want 1 3 fffffffb 0",
                  out_valid, out_class, out_score, out_error);
      end
      @(posedge clk);
      #1;
      checks++;
      if (frame_count !== 16'd2) begin
         errors++;
         $display("FAIL neg_fc fc=%0d want 2", frame_count);
      end
   endtask

   task automatic test_short();
      vals[0] = 32'd7;
      vals[1] = 32'd30;
      vals[2] = -32'sd2;
      vals[3] = 32'd30;
      vals[4] = 32'd1;
      send_frame(5, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_class !== 4'd1 ||
          out_score !== 32'd30 || out_error !== 1'b1) begin
         errors++;
         $display("FAIL short ov=%b cls=%0d sc=%0d err=%b want 1 1 30 1",
                  out_valid, out_class, out_score, out_error);
      end
      rd_addr = 4'd2;
      @(posedge clk);
      #1;
      checks++;
      if (rd_data !== 32'hFFFFFFFE || frame_count !== 16'd3) begin
         errors++;
         $display("FAIL short_rd rd=%h fc=%0d want fffffffe 3",
                  rd_data, frame_count);
      end
   endtask

   task automatic test_long();
      for (int i = 0; i < 10; i++) vals[i] = 32'(3 * i);
      vals[4] = 32'd50;
      send_frame(10, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_class !== 4'd4 ||
          out_score !== 32'd50 || out_error !== 1'b1) begin
         errors++;
         $display("FAIL long ov=%b cls=%0d sc=%0d err=%b want 1 4 50 1",
                  out_valid, out_class, out_score, out_error);
      end
      @(posedge clk);
      #1;
      checks++;
      if (frame_count !== 16'd4) begin
         errors++;
         $display("FAIL long_fc fc=%0d want 4", frame_count);
      end
   endtask

   task automatic test_stall();
      int bad = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) vals[i] = 32'(i + 1);
      vals[2] = 32'd99;
      send_frame(10, 1'b1);
      in_valid = 1'b1;
      in_data  = 32'hDEAD;
      for (int c = 0; c < 20; c++) begin
         if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
             out_class !== 4'd2 || out_score !== 32'd99 ||
             out_error !== 1'b0) bad++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stall_hold bad_cycles=%0d want 0", bad);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      rd_addr = 4'd0;
      @(posedge clk);
      #1;
      checks++;
      if (frame_count !== 16'd5 || rd_data !== 32'd1) begin
         errors++;
         $display("FAIL stall_done fc=%0d rd=%h want 5 1",
                  frame_count, rd_data);
      end
   endtask

   task automatic test_reset_midframe();
      int seen = 0;
      for (int i = 0; i < 10; i++) vals[i] = 32'(i);
      send_frame(7, 1'b0);
      rstb = 1'b1;
      @(posedge clk);
      #1;
      rstb = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (out_valid !== 1'b0) seen++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (seen != 0 || frame_count !== 16'd0) begin
         errors++;
         $display("FAIL rst_mid ov_cycles=%0d fc=%0d want 0 0",
                  seen, frame_count);
      end
      for (int i = 0; i < 10; i++) vals[i] = 32'(i);
      vals[6] = 32'd1000;
      send_frame(10, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_class !== 4'd6 ||
          out_score !== 32'd1000 || out_error !== 1'b0) begin
         errors++;
         $display("FAIL rst_clean ov=%b cls=%0d sc=%0d err=%b want 1 6 1000 0",
                  out_valid, out_class, out_score, out_error);
      end
      @(posedge clk);
      #1;
      checks++;
      if (frame_count !== 16'd1) begin
         errors++;
         $display("FAIL rst_fc fc=%0d want 1", frame_count);
      end
   endtask

   task automatic test_back_to_back();
      int beats = 0;
      int results = 0;
      int cycles = 0;
      int badcls = 0;
      bit rdy;
      bit res;
      out_ready = 1'b1;
      while (results < 5 && cycles < 200) begin
         in_valid = 1'b1;
         in_data  = ((beats % 10) == (beats / 10)) ? 32'd500
                                                   : 32'(beats % 10);
         in_last  = (beats % 10) == 9;
         #1;
         rdy = in_ready;
         res = out_valid;
         if (res && out_class !== 4'(results)) badcls++;
         @(posedge clk);
         #1;
         cycles++;
         if (rdy) beats++;
         if (res) results++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      checks++;
      if (cycles != 55 || results != 5) begin
         errors++;
         $display("FAIL b2b_rate cycles=%0d results=%0d want 55 5",
                  cycles, results);
      end
      checks++;
      if (badcls != 0 || frame_count !== 16'd6) begin
         errors++;
         $display("FAIL b2b_result badcls=%0d fc=%0d want 0 6",
                  badcls, frame_count);
      end
   endtask

   initial begin
      test_reset();
      test_ascending();
      test_negative();
      test_short();
      test_long();
      test_stall();
      test_reset_midframe();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
